// File: rtl/vpg_mode_ctrl_pkg.sv
// vpg_ctrl_pkg: mode-width helper, button levels and mode limits shared with vpg
package vpg_ctrl_pkg;
  localparam int MAX_MODES = 16;
  localparam logic BTN_RELEASED = 1'b1;
  localparam logic BTN_PRESSED = 1'b0;
  function automatic int mode_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/vpg_mode_ctrl_if.sv
// vpg_mode_ctrl_if: host load strobe/value into the controller; current mode and change pulse out
interface vpg_mode_ctrl_if
  import vpg_ctrl_pkg::*;
#(parameter int MODE_W = mode_w(MAX_MODES));
  logic mode_load;
  logic [MODE_W-1:0] mode_load_val;
  logic [MODE_W-1:0] mode;
  logic mode_change;
  modport master(output mode_load, mode_load_val, input mode, mode_change);
  modport slave(input mode_load, mode_load_val, output mode, mode_change);
endinterface

// File: rtl/vpg_mode_ctrl_btn_debounce.sv
// btn_debounce: 2-FF sync of an active-low button (btn_n), tick-sampled debounce, one-cycle press event out
module btn_debounce
  import vpg_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  input  logic tick,
  output logic press
);
  logic [1:0] sync;
  logic deb, armed, accept;
  logic [3:0] cnt;
  assign accept = tick && sync[1] != deb && cnt == 4'(DEBOUNCE_TICKS - 1);
  // armed stays low until a released level is sampled, so a button held through reset cannot fire
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= {2{BTN_RELEASED}};
      deb <= BTN_RELEASED;
      cnt <= '0;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], btn_n};
      press <= accept && deb == BTN_RELEASED && armed;
      if (tick) begin
        armed <= armed || sync[1] == BTN_RELEASED;
        cnt <= (sync[1] == deb || accept) ? '0 : cnt + 1'b1;
        if (accept) deb <= sync[1];
      end
    end
endmodule

// File: rtl/vpg_mode_ctrl.sv
// vpg_mode_ctrl: prescaler (tick, heartbeat), next/prev button debounce and host load driving the registered mode on bus
module vpg_mode_ctrl
  import vpg_ctrl_pkg::*;
#(
  parameter int NUM_MODES = 10,
  parameter int RESET_MODE = 0,
  parameter int DIV_WIDTH = 13,
  parameter int DEBOUNCE_TICKS = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_next_n,
  input  logic btn_prev_n,
  output logic tick,
  output logic heartbeat,
  vpg_mode_ctrl_if.slave bus
);
  localparam int MODE_W = mode_w(NUM_MODES);
  localparam logic [MODE_W:0] LAST = (MODE_W + 1)'(NUM_MODES - 1);
  logic [DIV_WIDTH-1:0] div;
  logic press_next, press_prev;
  logic [MODE_W:0] cur, ld, up, dn, nxt;
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_next (
    .clk, .reset_n, .btn_n(btn_next_n), .tick, .press(press_next)
  );
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_prev (
    .clk, .reset_n, .btn_n(btn_prev_n), .tick, .press(press_prev)
  );
  assign heartbeat = div[DIV_WIDTH-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div <= '0;
      tick <= 1'b0;
    end else begin
      div <= div + 1'b1;
      tick <= &div;
    end
  // one extra bit so +1/-1 and the load clamp never wrap silently
  always_comb begin
    cur = {1'b0, bus.mode};
    ld = ({1'b0, bus.mode_load_val} > LAST) ? LAST : {1'b0, bus.mode_load_val};
    up = (cur == LAST) ? (WRAP ? '0 : cur) : cur + 1'b1;
    dn = (cur == '0) ? (WRAP ? LAST : cur) : cur - 1'b1;
    nxt = bus.mode_load ? ld :
          (press_next && press_prev) ? cur :
          press_next ? up :
          press_prev ? dn : cur;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.mode <= MODE_W'(RESET_MODE);
      bus.mode_change <= 1'b0;
    end else begin
      bus.mode <= nxt[MODE_W-1:0];
      bus.mode_change <= nxt != cur;
    end
endmodule

// File: doc/vpg_mode_ctrl.md
# vpg_mode_ctrl

Parametrised video-mode selection controller for the HDMI TX top level. It replaces the single-button mode stepper and its external clock-enable divider. The block generates its own debounce tick, debounces separate next/previous buttons and steps through `NUM_MODES` modes. It also accepts a direct mode load from a host register and issues a one-cycle `mode_change` pulse to the pattern generator whenever the mode actually changes.

## Interface
- `NUM_MODES`, default 10: number of selectable modes, 2..16. Legal values are 0..NUM_MODES-1.
- `RESET_MODE`, default 0: mode after reset. Must be < NUM_MODES.
- `DIV_WIDTH`, default 13: prescaler width. One tick every 2^DIV_WIDTH clk cycles.
- `DEBOUNCE_TICKS`, default 4: consecutive tick samples required to accept a button level change. Range 1..15.
- `WRAP`, default 1: 1 = wrap at ends; 0 = saturate at ends.
- `clk`  in  1  control clock (1.2 MHz in the default build).
- `reset_n`  in  1  reset, asynchronous, active-low.
- `btn_next_n`  in  1  asynchronous button, active-low; a press steps +1.
- `btn_prev_n`  in  1  asynchronous button, active-low; a press steps -1.
- `mode_load`  in  1  synchronous one-cycle strobe that loads `mode_load_val`.
- `mode_load_val`  in  MODE_W  requested mode. MODE_W = $clog2(NUM_MODES).
- `mode`  out  MODE_W  current mode, registered.
- `mode_change`  out  1  one-cycle pulse, coincident with the first cycle of a new `mode` value.
- `tick`  out  1  one-cycle prescaler enable, exported for other slow logic.
- `heartbeat`  out  1  MSB of the prescaler, intended for an LED.

## Operation
- **Synchroniser:** each button passes through a 2-FF synchroniser before any other logic.
- **Prescaler:**
  - Free-running DIV_WIDTH-bit counter `div`.
  - `tick` is registered: it is high in the cycle after `div` is all-ones.
  - `heartbeat` = div[DIV_WIDTH-1].
- **Debounce, per button:**
  - State `deb` (1 = released) and counter `cnt`. Sampling happens only on `tick`.
  - If the synchronised level equals `deb`, `cnt` goes to 0.
  - Otherwise `cnt` increments. When the sample would be the DEBOUNCE_TICKS-th consecutive differing one, `deb` takes the sample and `cnt` goes to 0.
  - A press event is a `deb` 1→0 transition. Releases generate no event.
- **Mode update priority:**
  1. `mode_load` first. A value ≥ NUM_MODES is clamped to NUM_MODES-1. If the resulting value equals `mode`, there is no pulse.
  2. Both press events in the same tick cancel: no change.
  3. Next: if mode = NUM_MODES-1, the result is 0 when WRAP=1; when WRAP=0, mode is unchanged with no pulse.
  4. Prev: if mode = 0, the result is NUM_MODES-1 when WRAP=1; when WRAP=0, mode is unchanged with no pulse.
- **Pending events:** a press event arriving in the same cycle as `mode_load` is discarded. Events are not queued.
- **`mode_change`** asserts only when `mode` takes a different value.

## Timing
- **Reset values:**
  - `mode` = RESET_MODE.
  - `mode_change`, `tick` and `heartbeat` = 0.
  - `div` and `cnt` = 0; `deb` = 1; synchroniser flops = 1.
- **Reset mid-operation** aborts any partial debounce. A button held through reset release must first be seen released and then pressed again before it generates an event.
- **Button latency:** 2 clk cycles of synchroniser, then DEBOUNCE_TICKS ticks.
  - `deb` updates on the clk edge where the accepting `tick` is high.
  - `mode`/`mode_change` update on the following edge. This gives 1 clk of latency after `deb`.
- **Load latency:** `mode`/`mode_change` update on the edge after `mode_load` is sampled high (1 cycle).
- **Pulse widths:** `mode_change` is exactly 1 cycle. `tick` is exactly 1 cycle, with period 2^DIV_WIDTH.
- **Arithmetic:** all mode arithmetic is done in MODE_W+1 bits before the compare/clamp, so there is no silent overflow.

## Structure
- Package `vpg_ctrl_pkg` holds:
  - the `mode_w(n)` function;
  - the `BTN_RELEASED`/`BTN_PRESSED` constants;
  - limits shared with `vpg` (maximum mode count 16).
- Sub-module `btn_debounce`, parameter DEBOUNCE_TICKS: synchroniser plus debounce counter, with a `press` event output. It is instantiated twice.
- Prescaler, mode register and priority logic live in `vpg_mode_ctrl`.

## Test plan
All scenarios use DIV_WIDTH=4, DEBOUNCE_TICKS=3, NUM_MODES=5, RESET_MODE=0, WRAP=1 unless stated otherwise.
- **Reset and tick:** release reset → `tick` pulses every 16 cycles. `mode`=0, `mode_change`=0, `heartbeat` toggles every 8 cycles.
- **Clean next press:** hold `btn_next_n`=0 across 3 ticks → `mode` becomes 1 one cycle after the 3rd accepting tick, with a 1-cycle `mode_change`. Release produces no change.
- **Bounce:** toggle `btn_next_n` every tick for 10 ticks, then hold high → `mode` stays 0 and there are no pulses.
- **Wrap:** five next presses → 1,2,3,4,0. Then one prev press → 4. Rerun with WRAP=0: at 4, next gives no change and no pulse; at 0, prev gives no change and no pulse.
- **Simultaneous presses:** both buttons pressed with the same timing → no change. Then `mode_load`=7 → `mode`=4 with a pulse. Then `mode_load`=4 → no pulse.
- **Reset during a press:** assert `reset_n` while `btn_prev_n` is held mid-debounce → `mode`=0. The button held through release produces no event until it is released and pressed again.
